// File: rtl/kmeans_pkg.sv
// Shared K-means parameters, loader state encoding and the point-row address helper.
package kmeans_pkg;

   localparam int DATA_W     = 13;
   localparam int DIM        = 14;
   localparam int NUM_CENT   = 4;
   localparam int MAX_POINTS = 256;
   localparam int MAT_AW     = 12;
   localparam int CENT_AW    = 6;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      CENT,
      PTS,
      GO,
      WAIT,
      ERR
   } loader_state_e;

   // Base matrix address of a point row. Point indices are < MAX_POINTS once
   // validated, so the product fits in MAT_AW bits.
   function automatic logic [MAT_AW-1:0] row_base(input logic [DATA_W-1:0] idx);
      logic [MAT_AW-1:0] i;
      i = idx[MAT_AW-1:0];
      return i * MAT_AW'(DIM);
   endfunction

endpackage

// File: rtl/kmeans_input_loader_if.sv
// Job word stream into the K-means loader.
// A word moves on a rising edge where s_valid && s_ready; s_data/s_last stay stable while s_valid waits.
interface kmeans_input_loader_if;
   import kmeans_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;

   modport master (output s_valid, output s_data, output s_last, input s_ready);
   modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/kmeans_input_loader.sv
// Loads one K-means job (header, centroids, points) from a word stream into core storage,
// then starts the core and waits for it to finish.
module kmeans_input_loader
   import kmeans_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   kmeans_input_loader_if.slave strm,
   output logic                 mat_we,
   output logic [MAT_AW-1:0]    mat_addr,
   output logic [DATA_W-1:0]    mat_wdata,
   output logic                 cent_we,
   output logic [CENT_AW-1:0]   cent_addr,
   output logic [DATA_W-1:0]    cent_wdata,
   output logic [DATA_W-1:0]    threshold,
   output logic [DATA_W-1:0]    first_point_index,
   output logic [DATA_W-1:0]    last_point_index,
   output logic                 go,
   input  logic                 core_done,
   output logic                 err,
   output loader_state_e        dbg_state
);

   localparam logic [CENT_AW-1:0] HDR_LAST  = CENT_AW'(2);
   localparam logic [CENT_AW-1:0] CENT_LAST = CENT_AW'(NUM_CENT*DIM-1);
   localparam logic [DATA_W-1:0]  MAX_PTS_D = DATA_W'(MAX_POINTS);
   localparam logic [MAT_AW-1:0]  DIM_M     = MAT_AW'(DIM);

   loader_state_e      state, state_next;
   logic [CENT_AW-1:0] cnt;
   logic [MAT_AW-1:0]  addr;
   logic [MAT_AW-1:0]  pts_end;
   logic               ready;
   logic               xfer;
   logic               hdr_bad;
   logic               wr_cent;
   logic               wr_mat;
   logic               set_err;
   logic               clr_err;

   assign strm.s_ready = ready;
   assign dbg_state    = state;
   assign xfer         = strm.s_valid && ready;
   assign hdr_bad      = (strm.s_data < first_point_index) || (strm.s_data >= MAX_PTS_D);
   assign pts_end      = row_base(last_point_index) + DIM_M - MAT_AW'(1);

   // A framing error on a word that carries s_last has already ended the job's
   // stream, so it returns straight to IDLE instead of draining into the next job.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      wr_cent    = 1'b0;
      wr_mat     = 1'b0;
      set_err    = 1'b0;
      clr_err    = 1'b0;
      case (state)
         IDLE: state_next = HDR;
         HDR: begin
            ready = 1'b1;
            if (xfer) begin
               if (cnt == HDR_LAST) begin
                  if (hdr_bad || strm.s_last) begin
                     set_err    = 1'b1;
                     state_next = strm.s_last ? IDLE : ERR;
                  end else begin
                     clr_err    = 1'b1;
                     state_next = CENT;
                  end
               end else if (strm.s_last) begin
                  set_err    = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         CENT: begin
            ready = 1'b1;
            if (xfer) begin
               if (strm.s_last) begin
                  set_err    = 1'b1;
                  state_next = IDLE;
               end else begin
                  wr_cent = 1'b1;
                  if (cnt == CENT_LAST) state_next = PTS;
               end
            end
         end
         PTS: begin
            ready = 1'b1;
            if (xfer) begin
               if (addr == pts_end) begin
                  if (strm.s_last) begin
                     wr_mat     = 1'b1;
                     state_next = GO;
                  end else begin
                     set_err    = 1'b1;
                     state_next = ERR;
                  end
               end else if (strm.s_last) begin
                  set_err    = 1'b1;
                  state_next = IDLE;
               end else begin
                  wr_mat = 1'b1;
               end
            end
         end
         GO:   state_next = WAIT;
         WAIT: if (core_done) state_next = IDLE;
         ERR: begin
            ready = 1'b1;
            if (xfer && strm.s_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         addr  <= '0;
      end else begin
         state <= state_next;
         if (state_next != state) cnt <= '0;
         else if (xfer)           cnt <= cnt + CENT_AW'(1);
         if (state == HDR && xfer && cnt == HDR_LAST) addr <= row_base(first_point_index);
         else if (wr_mat)                             addr <= addr + MAT_AW'(1);
      end
   end

   // Header latches only move while a header is being received.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         threshold         <= '0;
         first_point_index <= '0;
         last_point_index  <= '0;
         err               <= 1'b0;
         go                <= 1'b0;
      end else begin
         if (state == HDR && xfer) begin
            if (cnt == CENT_AW'(0)) threshold         <= strm.s_data;
            if (cnt == CENT_AW'(1)) first_point_index <= strm.s_data;
            if (cnt == HDR_LAST)    last_point_index  <= strm.s_data;
         end
         if (set_err)      err <= 1'b1;
         else if (clr_err) err <= 1'b0;
         go <= (state == GO);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mat_we     <= 1'b0;
         mat_addr   <= '0;
         mat_wdata  <= '0;
         cent_we    <= 1'b0;
         cent_addr  <= '0;
         cent_wdata <= '0;
      end else begin
         mat_we  <= wr_mat;
         cent_we <= wr_cent;
         if (wr_mat) begin
            mat_addr  <= addr;
            mat_wdata <= strm.s_data;
         end
         if (wr_cent) begin
            cent_addr  <= cnt;
            cent_wdata <= strm.s_data;
         end
      end
   end

endmodule

// File: tb/tb_kmeans_input_loader.sv
// Scoreboarded bench for the K-means input loader: full, partial, framing-error,
// bubbled and reset-interrupted jobs.
module tb_kmeans_input_loader;
   import kmeans_pkg::*;

   logic                clk;
   logic                rst;
   logic                mat_we;
   logic [MAT_AW-1:0]   mat_addr;
   logic [DATA_W-1:0]   mat_wdata;
   logic                cent_we;
   logic [CENT_AW-1:0]  cent_addr;
   logic [DATA_W-1:0]   cent_wdata;
   logic [DATA_W-1:0]   threshold;
   logic [DATA_W-1:0]   first_point_index;
   logic [DATA_W-1:0]   last_point_index;
   logic                go;
   logic                core_done;
   logic                err;
   loader_state_e       dbg_state;

   kmeans_input_loader_if sif ();

   kmeans_input_loader dut (
      .clk               (clk),
      .rst               (rst),
      .strm              (sif.slave),
      .mat_we            (mat_we),
      .mat_addr          (mat_addr),
      .mat_wdata         (mat_wdata),
      .cent_we           (cent_we),
      .cent_addr         (cent_addr),
      .cent_wdata        (cent_wdata),
      .threshold         (threshold),
      .first_point_index (first_point_index),
      .last_point_index  (last_point_index),
      .go                (go),
      .core_done         (core_done),
      .err               (err),
      .dbg_state         (dbg_state)
   );

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int go_cnt = 0;
   int go_cyc = 0;
   int mat_cnt = 0;
   int cent_cnt = 0;
   int last_we_cyc = 0;
   logic [MAT_AW+DATA_W-1:0]  mat_q[$];
   logic [CENT_AW+DATA_W-1:0] cent_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mat_we) begin
         mat_cnt++;
         last_we_cyc = cyc;
         checks++;
         if (mat_q.size() == 0) begin
            $display("FAIL mat_unexpected: got addr=%0d data=%0d, required no write", mat_addr, mat_wdata);
         end else begin
            logic [MAT_AW+DATA_W-1:0] e;
            e = mat_q.pop_front();
            if ({mat_addr, mat_wdata} !== e)
               $display("FAIL mat_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                        mat_addr, mat_wdata, e[MAT_AW+DATA_W-1:DATA_W], e[DATA_W-1:0]);
            else passes++;
         end
      end
      if (cent_we) begin
         cent_cnt++;
         checks++;
         if (cent_q.size() == 0) begin
            $display("FAIL cent_unexpected: got addr=%0d data=%0d, required no write", cent_addr, cent_wdata);
         end else begin
            logic [CENT_AW+DATA_W-1:0] e;
            e = cent_q.pop_front();
            if ({cent_addr, cent_wdata} !== e)
               $display("FAIL cent_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                        cent_addr, cent_wdata, e[CENT_AW+DATA_W-1:DATA_W], e[DATA_W-1:0]);
            else passes++;
         end
      end
      if (go) begin
         go_cnt++;
         go_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [DATA_W-1:0] d, input logic last, input int gap);
      int w;
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
         sif.s_valid = 1'b0;
         tick();
      end
      sif.s_valid = 1'b1;
      sif.s_data  = d;
      sif.s_last  = last;
      w = 0;
      while (!sif.s_ready && w < 2000) begin
         tick();
         w++;
      end
      if (!sif.s_ready) begin
         checks++;
         $display("FAIL ready_timeout: s_ready=0 for %0d cycles, required 1", w);
      end else begin
         tick();
      end
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
   endtask

   // end_at > 0: s_last on that point word (early); end_at < 0: final word without s_last.
   task automatic run_job(input int thr, input int first, input int last, input int gap, input int end_at);
      int n;
      logic [DATA_W-1:0] d;
      n = (last - first + 1) * DIM;
      send_word(DATA_W'(thr), 1'b0, gap);
      send_word(DATA_W'(first), 1'b0, gap);
      send_word(DATA_W'(last), 1'b0, gap);
      for (int i = 0; i < NUM_CENT*DIM; i++) begin
         d = DATA_W'($urandom_range(0, 8191));
         cent_q.push_back({CENT_AW'(i), d});
         send_word(d, 1'b0, gap);
      end
      for (int i = 0; i < n; i++) begin
         d = DATA_W'($urandom_range(0, 8191));
         if (end_at > 0 && i == end_at - 1) begin
            send_word(d, 1'b1, gap);
            break;
         end
         if (end_at < 0 && i == n - 1) begin
            send_word(d, 1'b0, gap);
            break;
         end
         mat_q.push_back({MAT_AW'(first*DIM + i), d});
         send_word(d, (i == n - 1), gap);
      end
   endtask

   task automatic finish_good(input int thr, input int first, input int last, input int g0, input int m0);
      int k;
      k = 0;
      while (go_cnt == g0 && k < 20) begin
         tick();
         k++;
      end
      checks++;
      if (go_cnt != g0 + 1) $display("FAIL go_count: got %0d pulses, required 1", go_cnt - g0);
      else passes++;
      checks++;
      if (go_cyc != last_we_cyc + 1) $display("FAIL go_timing: go at cycle %0d, required %0d", go_cyc, last_we_cyc + 1);
      else passes++;
      checks++;
      if (mat_cnt - m0 != (last - first + 1) * DIM || mat_q.size() != 0 || cent_q.size() != 0)
         $display("FAIL write_count: got %0d mat writes (%0d/%0d left), required %0d",
                  mat_cnt - m0, mat_q.size(), cent_q.size(), (last - first + 1) * DIM);
      else passes++;
      repeat (5) tick();
      checks++;
      if (sif.s_ready !== 1'b0 || dbg_state !== WAIT || go_cnt != g0 + 1 || err !== 1'b0)
         $display("FAIL wait_hold: got ready=%0b state=%0d go_pulses=%0d err=%0b, required 0 WAIT 1 0",
                  sif.s_ready, dbg_state, go_cnt - g0, err);
      else passes++;
      checks++;
      if (threshold !== DATA_W'(thr) || first_point_index !== DATA_W'(first) || last_point_index !== DATA_W'(last))
         $display("FAIL header_latch: got %0d/%0d/%0d, required %0d/%0d/%0d",
                  threshold, first_point_index, last_point_index, thr, first, last);
      else passes++;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      checks++;
      if (dbg_state !== IDLE || sif.s_ready !== 1'b0)
         $display("FAIL done_idle: got state=%0d ready=%0b, required IDLE 0", dbg_state, sif.s_ready);
      else passes++;
      tick();
      checks++;
      if (sif.s_ready !== 1'b1) $display("FAIL ready_after_idle: got %0b, required 1", sif.s_ready);
      else passes++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (sif.s_ready !== 1'b0 || mat_we !== 1'b0 || cent_we !== 1'b0 || go !== 1'b0 || err !== 1'b0 ||
          threshold !== '0 || first_point_index !== '0 || last_point_index !== '0 || dbg_state !== IDLE)
         $display("FAIL reset_outputs: got ready=%0b mat_we=%0b cent_we=%0b go=%0b err=%0b, required all 0",
                  sif.s_ready, mat_we, cent_we, go, err);
      else passes++;
      rst = 1'b0;
      checks++;
      if (sif.s_ready !== 1'b0) $display("FAIL ready_first_cycle: got %0b, required 0", sif.s_ready);
      else passes++;
      tick();
      checks++;
      if (sif.s_ready !== 1'b1 || dbg_state !== HDR)
         $display("FAIL ready_second_cycle: got ready=%0b state=%0d, required 1 HDR", sif.s_ready, dbg_state);
      else passes++;
   endtask

   task automatic test_full_job();
      int g0, m0;
      g0 = go_cnt;
      m0 = mat_cnt;
      run_job(5, 0, MAX_POINTS - 1, 0, 0);
      finish_good(5, 0, MAX_POINTS - 1, g0, m0);
   endtask

   task automatic test_partial_job(input int gap);
      int g0, m0;
      g0 = go_cnt;
      m0 = mat_cnt;
      run_job(77, 10, 12, gap, 0);
      finish_good(77, 10, 12, g0, m0);
   endtask

   task automatic test_bad_header(input int first, input int last);
      int g0, m0, c0;
      g0 = go_cnt;
      m0 = mat_cnt;
      c0 = cent_cnt;
      send_word(DATA_W'(9), 1'b0, 0);
      send_word(DATA_W'(first), 1'b0, 0);
      send_word(DATA_W'(last), 1'b0, 0);
      for (int i = 0; i < 6; i++) send_word(DATA_W'($urandom_range(0, 8191)), 1'b0, 0);
      checks++;
      if (err !== 1'b1 || dbg_state !== ERR || sif.s_ready !== 1'b1)
         $display("FAIL hdr_err: got err=%0b state=%0d ready=%0b, required 1 ERR 1", err, dbg_state, sif.s_ready);
      else passes++;
      send_word(DATA_W'(1), 1'b1, 0);
      repeat (3) tick();
      checks++;
      if (mat_cnt != m0 || cent_cnt != c0 || go_cnt != g0 || err !== 1'b1)
         $display("FAIL hdr_err_quiet: got mat=%0d cent=%0d go=%0d err=%0b, required 0 0 0 1",
                  mat_cnt - m0, cent_cnt - c0, go_cnt - g0, err);
      else passes++;
      g0 = go_cnt;
      m0 = mat_cnt;
      run_job(3, 2, 2, 0, 0);
      finish_good(3, 2, 2, g0, m0);
   endtask

   task automatic test_early_last();
      int g0, m0;
      g0 = go_cnt;
      m0 = mat_cnt;
      run_job(4, 10, 12, 0, 20);
      repeat (4) tick();
      checks++;
      if (mat_cnt - m0 != 19 || mat_q.size() != 0 || go_cnt != g0 || err !== 1'b1)
         $display("FAIL early_last: got writes=%0d go=%0d err=%0b, required 19 0 1", mat_cnt - m0, go_cnt - g0, err);
      else passes++;
   endtask

   task automatic test_missing_last();
      int g0, m0;
      g0 = go_cnt;
      m0 = mat_cnt;
      run_job(6, 1, 1, 0, -1);
      repeat (2) tick();
      checks++;
      if (mat_cnt - m0 != 13 || go_cnt != g0 || err !== 1'b1 || dbg_state !== ERR)
         $display("FAIL missing_last: got writes=%0d go=%0d err=%0b state=%0d, required 13 0 1 ERR",
                  mat_cnt - m0, go_cnt - g0, err, dbg_state);
      else passes++;
      send_word(DATA_W'(0), 1'b1, 0);
      tick();
      checks++;
      if (dbg_state !== HDR) $display("FAIL drain_exit: got state=%0d, required HDR", dbg_state);
      else passes++;
   endtask

   task automatic test_reset_mid_cent();
      int g0, m0;
      send_word(DATA_W'(8), 1'b0, 0);
      send_word(DATA_W'(0), 1'b0, 0);
      send_word(DATA_W'(1), 1'b0, 0);
      for (int i = 0; i < 30; i++) begin
         logic [DATA_W-1:0] d;
         d = DATA_W'($urandom_range(0, 8191));
         if (i < 29) cent_q.push_back({CENT_AW'(i), d});
         send_word(d, 1'b0, 0);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mat_we !== 1'b0 || cent_we !== 1'b0 || go !== 1'b0 || sif.s_ready !== 1'b0 || dbg_state !== IDLE ||
          cent_addr !== '0 || threshold !== '0 || cent_q.size() != 0)
         $display("FAIL reset_abort: got cent_we=%0b ready=%0b state=%0d pending=%0d, required 0 0 IDLE 0",
                  cent_we, sif.s_ready, dbg_state, cent_q.size());
      else passes++;
      tick();
      rst = 1'b0;
      g0 = go_cnt;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      checks++;
      if (dbg_state !== HDR || go_cnt != g0)
         $display("FAIL done_in_idle: got state=%0d go=%0d, required HDR 0", dbg_state, go_cnt - g0);
      else passes++;
      m0 = mat_cnt;
      run_job(11, 0, 1, 0, 0);
      finish_good(11, 0, 1, g0, m0);
   endtask

   initial begin
      rst         = 1'b1;
      core_done   = 1'b0;
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      sif.s_last  = 1'b0;
      test_reset();
      test_full_job();
      test_partial_job(0);
      test_bad_header(7, 3);
      test_bad_header(0, 256);
      test_early_last();
      test_missing_last();
      test_partial_job(50);
      test_reset_mid_cent();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
